// File: rtl/ibex_xif_pkg.sv
// Shared types for the CV-X-IF register-file writeback arbiter.
// sb_entry_t is one scoreboard row per offloaded instruction id.
// xif_result_t is the result beat in the default id and data widths.
package ibex_xif_pkg;

  localparam int XifIdW   = 4;
  localparam int XifDataW = 32;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
  } sb_entry_t;

  typedef struct packed {
    logic [XifIdW-1:0]   id;
    logic                we;
    logic [XifDataW-1:0] data;
  } xif_result_t;

endpackage

// File: rtl/ibex_xif_rf_scoreboard.sv
// Outstanding-offload table indexed by XIF id.
// It tracks the destination register of each in-flight instruction and derives
// the pending-register vector and the ID-stage hazard from it.
// A clear and a set of the same id in one cycle apply the clear first, so the set wins.
module ibex_xif_rf_scoreboard
  import ibex_xif_pkg::*;
#(
  parameter int IdWidth = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid,
  input  logic [IdWidth-1:0] issue_id,
  input  logic [4:0]         issue_rd,
  input  logic               issue_we,
  input  logic               kill_valid,
  input  logic [IdWidth-1:0] kill_id,
  input  logic               retire_valid,
  input  logic [IdWidth-1:0] retire_id,
  input  logic [IdWidth-1:0] lookup_id,
  output logic               lookup_valid,
  output logic [4:0]         lookup_rd,
  output logic               lookup_we,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [4:0]         rd,
  input  logic [4:0]         chk_addr,
  output logic               chk_pending,
  output logic               hazard,
  output logic               busy,
  output logic               issue_err,
  output logic               kill_err
);

  localparam int NumIds = 2 ** IdWidth;

  sb_entry_t   tbl_q [NumIds];
  sb_entry_t   tbl_d [NumIds];
  logic [31:0] pending;
  logic        rec_we;
  logic        issue_cleared;

  // Table register; reset drops every outstanding entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumIds; i++) tbl_q[i] <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  // Next table: kill and retire clears first, then the new issue.
  always_comb begin
    tbl_d  = tbl_q;
    rec_we = issue_we & (issue_rd != 5'd0);
    if (kill_valid)   tbl_d[kill_id].valid = 1'b0;
    if (retire_valid) tbl_d[retire_id] = '0;
    if (issue_valid) begin
      tbl_d[issue_id] = '{valid: 1'b1, rd: (rec_we ? issue_rd : 5'd0), we: rec_we};
    end
  end

  // Pending vector from the registered table; x0 is never pending.
  always_comb begin
    pending = '0;
    busy    = 1'b0;
    for (int i = 0; i < NumIds; i++) begin
      if (tbl_q[i].valid) begin
        busy = 1'b1;
        if (tbl_q[i].we) pending[tbl_q[i].rd] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

  // Lookups, hazard and table-level protocol checks.
  always_comb begin
    lookup_valid  = tbl_q[lookup_id].valid;
    lookup_rd     = tbl_q[lookup_id].rd;
    lookup_we     = tbl_q[lookup_id].we;
    hazard        = pending[rs1] | pending[rs2] | pending[rd];
    chk_pending   = pending[chk_addr];
    issue_cleared = (kill_valid & (kill_id == issue_id)) |
                    (retire_valid & (retire_id == issue_id));
    issue_err     = issue_valid & tbl_q[issue_id].valid & ~issue_cleared;
    kill_err      = kill_valid & ~tbl_q[kill_id].valid;
  end

endmodule

// File: rtl/ibex_xif_rf_wb_arbiter.sv
// Register-file W1 write arbiter between core writeback and CV-X-IF results.
// Core writes always win. With IBEX_XIF_RF_ARB_SKID_EN defined, a result that
// collides with a core write is held in a one-entry skid buffer and drained on
// the first core-idle cycle. Without it, result_ready_o = !core_we_i, and results
// are only written directly.
// Handshake: a result transfers in a cycle where result_valid_i and
// result_ready_o are both high; result_ready_o never depends on result_valid_i.
module ibex_xif_rf_wb_arbiter
  import ibex_xif_pkg::*;
#(
  parameter bit RV32E     = 1'b0,
  parameter int DataWidth = 32,
  parameter int IdWidth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 core_we_i,
  input  logic [4:0]           core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  input  logic                 issue_valid_i,
  input  logic [IdWidth-1:0]   issue_id_i,
  input  logic [4:0]           issue_rd_i,
  input  logic                 issue_we_i,
  input  logic                 commit_valid_i,
  input  logic [IdWidth-1:0]   commit_id_i,
  input  logic                 commit_kill_i,
  input  logic                 result_valid_i,
  input  logic [IdWidth-1:0]   result_id_i,
  input  logic                 result_we_i,
  input  logic [DataWidth-1:0] result_data_i,
  output logic                 result_ready_o,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [4:0]           rd_i,
  output logic                 hazard_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 xif_busy_o,
  output logic                 err_o
);

  logic               res_fire;
  logic               lk_valid;
  logic [4:0]         lk_rd;
  logic               lk_we;
  logic               retire_valid;
  logic [IdWidth-1:0] retire_id;
  logic               chk_pending;
  logic               issue_err;
  logic               kill_err;
  logic               rv32e_bad;
  logic               err_d;
  logic               err_q;

`ifdef IBEX_XIF_RF_ARB_SKID_EN
  logic                 skid_valid;
  logic [IdWidth-1:0]   skid_id;
  logic [4:0]           skid_rd;
  logic                 skid_we;
  logic [DataWidth-1:0] skid_data;

  assign result_ready_o = ~skid_valid;

  // Skid buffer: capture a valid result that lost to a core write, drain when the core is idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_valid <= 1'b0;
      skid_id    <= '0;
      skid_rd    <= '0;
      skid_we    <= 1'b0;
      skid_data  <= '0;
    end else if (res_fire & core_we_i & lk_valid) begin
      skid_valid <= 1'b1;
      skid_id    <= result_id_i;
      skid_rd    <= lk_rd;
      skid_we    <= lk_we & result_we_i;
      skid_data  <= result_data_i;
    end else if (skid_valid & ~core_we_i) begin
      skid_valid <= 1'b0;
    end
  end
`else
  assign result_ready_o = ~core_we_i;
`endif

  assign res_fire = result_valid_i & result_ready_o;

  // W1 write mux: core, then buffered result, then direct result; retires the written id.
  always_comb begin
    rf_we_o      = 1'b0;
    rf_waddr_o   = core_waddr_i;
    rf_wdata_o   = core_wdata_i;
    retire_valid = 1'b0;
    retire_id    = result_id_i;
    if (core_we_i) begin
      rf_we_o = 1'b1;
    end
`ifdef IBEX_XIF_RF_ARB_SKID_EN
    else if (skid_valid) begin
      rf_we_o      = skid_we;
      rf_waddr_o   = skid_rd;
      rf_wdata_o   = skid_data;
      retire_valid = 1'b1;
      retire_id    = skid_id;
    end
`endif
    else if (res_fire) begin
      rf_we_o      = lk_valid & lk_we & result_we_i;
      rf_waddr_o   = lk_rd;
      rf_wdata_o   = result_data_i;
      retire_valid = lk_valid;
    end
  end

  ibex_xif_rf_scoreboard #(
    .IdWidth(IdWidth)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .issue_valid  (issue_valid_i),
    .issue_id     (issue_id_i),
    .issue_rd     (issue_rd_i),
    .issue_we     (issue_we_i),
    .kill_valid   (commit_valid_i & commit_kill_i),
    .kill_id      (commit_id_i),
    .retire_valid (retire_valid),
    .retire_id    (retire_id),
    .lookup_id    (result_id_i),
    .lookup_valid (lk_valid),
    .lookup_rd    (lk_rd),
    .lookup_we    (lk_we),
    .rs1          (rs1_i),
    .rs2          (rs2_i),
    .rd           (rd_i),
    .chk_addr     (core_waddr_i),
    .chk_pending  (chk_pending),
    .hazard       (hazard_o),
    .busy         (xif_busy_o),
    .issue_err    (issue_err),
    .kill_err     (kill_err)
  );

  // Protocol error sources, combined into a one-cycle registered pulse.
  always_comb begin
    rv32e_bad = 1'b0;
    if (RV32E) begin
      rv32e_bad = (issue_valid_i & issue_we_i & issue_rd_i[4]) |
                  (core_we_i & core_waddr_i[4]) | rs1_i[4] | rs2_i[4] | rd_i[4];
    end
    err_d = issue_err | kill_err | (res_fire & ~lk_valid) | rv32e_bad |
            (core_we_i & chk_pending);
  end

  // Error pulse register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_ibex_xif_rf_wb_arbiter.sv
// Bench for ibex_xif_rf_wb_arbiter: directed steps followed by random traffic,
// all checked against an id-table reference model kept in plain arrays.
module tb_ibex_xif_rf_wb_arbiter;

`ifdef IBEX_XIF_RF_ARB_SKID_EN
  localparam bit skid_en = 1'b1;
`else
  localparam bit skid_en = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_we = 0;
  logic [4:0]  core_waddr = 0;
  logic [31:0] core_wdata = 0;
  logic        issue_valid = 0;
  logic [3:0]  issue_id = 0;
  logic [4:0]  issue_rd = 0;
  logic        issue_we = 0;
  logic        commit_valid = 0;
  logic [3:0]  commit_id = 0;
  logic        commit_kill = 0;
  logic        result_valid = 0;
  logic [3:0]  result_id = 0;
  logic        result_we = 0;
  logic [31:0] result_data = 0;
  logic        result_ready;
  logic [4:0]  rs1 = 0, rs2 = 0, rd = 0;
  logic        hazard, rf_we, xif_busy, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  ibex_xif_rf_wb_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .issue_valid_i(issue_valid), .issue_id_i(issue_id), .issue_rd_i(issue_rd), .issue_we_i(issue_we),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .result_valid_i(result_valid), .result_id_i(result_id), .result_we_i(result_we),
    .result_data_i(result_data), .result_ready_o(result_ready),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .hazard_o(hazard),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .xif_busy_o(xif_busy), .err_o(err)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [16];
  bit          m_we    [16];
  logic [4:0]  m_rd    [16];
  bit          m_skid_v;
  logic [3:0]  m_skid_id;
  logic [4:0]  m_skid_rd;
  bit          m_skid_we;
  logic [31:0] m_skid_data;
  bit          m_err;

  function automatic bit pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    for (int i = 0; i < 16; i++)
      if (m_valid[i] && m_we[i] && m_rd[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_valid();
    for (int i = 0; i < 16; i++) if (m_valid[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    return skid_en ? !m_skid_v : !core_we;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_we[i] = 0; m_rd[i] = 0;
    end
    m_skid_v = 0; m_skid_id = 0; m_skid_rd = 0; m_skid_we = 0; m_skid_data = 0;
    m_err = 0;
  endtask

  // Compare every output against the model for the current inputs.
  task automatic check_outputs();
    bit ew, fire;
    logic [4:0] ea;
    logic [31:0] ed;
    fire = result_valid && m_ready();
    ew = 0; ea = 0; ed = 0;
    if (core_we) begin
      ew = 1; ea = core_waddr; ed = core_wdata;
    end else if (m_skid_v) begin
      ew = m_skid_we; ea = m_skid_rd; ed = m_skid_data;
    end else if (fire) begin
      ew = m_valid[result_id] && m_we[result_id] && result_we;
      ea = m_rd[result_id]; ed = result_data;
    end
    chk("ready", {31'd0, result_ready}, {31'd0, m_ready()});
    chk("rf_we", {31'd0, rf_we}, {31'd0, ew});
    if (ew) begin
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, ea});
      chk("rf_wdata", rf_wdata, ed);
    end
    chk("hazard", {31'd0, hazard}, {31'd0, pend(rs1) | pend(rs2) | pend(rd)});
    chk("busy", {31'd0, xif_busy}, {31'd0, any_valid()});
    chk("err", {31'd0, err}, {31'd0, m_err});
  endtask

  // Advance the model by one clock edge using the applied inputs.
  task automatic model_clock();
    bit fire, ok, kill, err_n;
    int ca, cb;
    fire = result_valid && m_ready();
    ok   = m_valid[result_id];
    kill = commit_valid && commit_kill;
    ca = kill ? int'(commit_id) : -1;
    cb = -1;
    err_n = (fire && !ok) || (kill && !m_valid[commit_id]) || (core_we && pend(core_waddr));
    if (core_we) begin
      if (fire && ok) begin
        m_skid_v = 1; m_skid_id = result_id; m_skid_rd = m_rd[result_id];
        m_skid_we = m_we[result_id] && result_we; m_skid_data = result_data;
      end
    end else if (m_skid_v) begin
      cb = int'(m_skid_id); m_skid_v = 0;
    end else if (fire && ok) begin
      cb = int'(result_id);
    end
    if (issue_valid && m_valid[issue_id] && int'(issue_id) != ca && int'(issue_id) != cb) err_n = 1;
    if (ca >= 0) m_valid[ca] = 0;
    if (cb >= 0) m_valid[cb] = 0;
    if (issue_valid) begin
      m_valid[issue_id] = 1;
      m_we[issue_id] = issue_we && (issue_rd != 5'd0);
      m_rd[issue_id] = issue_rd;
    end
    m_err = err_n;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle_inputs();
    core_we = 0; issue_valid = 0; commit_valid = 0; commit_kill = 0;
    result_valid = 0; result_we = 0; rs1 = 0; rs2 = 0; rd = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    idle_inputs();
    #1;
    chk("rst_ready", {31'd0, result_ready}, 32'd1);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_busy", {31'd0, xif_busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();
    step();

    // Issue id3 -> x5, hazard on rs1=5, then a direct result write.
    issue_valid = 1; issue_id = 3; issue_rd = 5; issue_we = 1;
    step();
    issue_valid = 0; rs1 = 5; #1;
    chk("hz_x5_set", {31'd0, hazard}, 32'd1);
    result_valid = 1; result_id = 3; result_we = 1; result_data = 32'hDEADBEEF; #1;
    chk("direct_we", {31'd0, rf_we}, 32'd1);
    chk("direct_addr", {27'd0, rf_waddr}, 32'd5);
    chk("direct_data", rf_wdata, 32'hDEADBEEF);
    step();
    result_valid = 0; #1;
    chk("hz_x5_clr", {31'd0, hazard}, 32'd0);

    // Id2 -> x7 collides with core write x9.
    issue_valid = 1; issue_id = 2; issue_rd = 7; issue_we = 1; rs1 = 0;
    step();
    issue_valid = 0;
    core_we = 1; core_waddr = 9; core_wdata = 32'h1;
    result_valid = 1; result_id = 2; result_we = 1; result_data = 32'h0000_0077; #1;
    chk("coll_core_we", {31'd0, rf_we}, 32'd1);
    chk("coll_core_addr", {27'd0, rf_waddr}, 32'd9);
    step();
`ifdef IBEX_XIF_RF_ARB_SKID_EN
    chk("skid_ready_low", {31'd0, result_ready}, 32'd0);
    result_valid = 0;
`endif
    core_we = 0; #1;
    chk("late_x7_we", {31'd0, rf_we}, 32'd1);
    chk("late_x7_addr", {27'd0, rf_waddr}, 32'd7);
    chk("late_x7_data", rf_wdata, 32'h0000_0077);
    step();
    result_valid = 0;

    // Issue id1 -> x4, then kill it.
    issue_valid = 1; issue_id = 1; issue_rd = 4; issue_we = 1;
    step();
    issue_valid = 0; rs1 = 4; #1;
    chk("hz_x4_set", {31'd0, hazard}, 32'd1);
    commit_valid = 1; commit_kill = 1; commit_id = 1;
    step();
    commit_valid = 0; commit_kill = 0; #1;
    chk("kill_hz", {31'd0, hazard}, 32'd0);
    chk("kill_busy", {31'd0, xif_busy}, 32'd0);
    chk("kill_rf_we", {31'd0, rf_we}, 32'd0);
    rs1 = 0;

    // Double issue of id0 and a result for unissued id6.
    issue_valid = 1; issue_id = 0; issue_rd = 12; issue_we = 1;
    step();
    step();
    issue_valid = 0;
    chk("err_double_issue", {31'd0, err}, 32'd1);
    commit_valid = 1; commit_kill = 1; commit_id = 0;
    step();
    commit_valid = 0; commit_kill = 0;
    result_valid = 1; result_id = 6; result_we = 1; result_data = 32'h1234;
    step();
    result_valid = 0;
    chk("err_bad_result", {31'd0, err}, 32'd1);
    step();
    chk("err_pulse_end", {31'd0, err}, 32'd0);

    // Reset with work in flight (skid full when the buffer exists).
    issue_valid = 1; issue_id = 5; issue_rd = 10; issue_we = 1;
    step();
    issue_valid = 0;
    core_we = 1; core_waddr = 11; core_wdata = 32'h55;
    result_valid = 1; result_id = 5; result_we = 1; result_data = 32'hAA;
    step();
    do_reset();
    rs1 = 10; #1;
    chk("post_rst_hz", {31'd0, hazard}, 32'd0);
    step();

    // Issue with rd=x0: no hazard, no RF write on its result.
    issue_valid = 1; issue_id = 4; issue_rd = 0; issue_we = 1; rs1 = 0;
    step();
    issue_valid = 0; #1;
    chk("x0_hz", {31'd0, hazard}, 32'd0);
    result_valid = 1; result_id = 4; result_we = 1; result_data = 32'hFFFF; #1;
    chk("x0_no_write", {31'd0, rf_we}, 32'd0);
    step();
    idle_inputs();
    step();

    // Random traffic with a mid-run reset.
    for (int n = 0; n < 600; n++) begin
      issue_valid  = ($urandom_range(0, 2) == 0);
      issue_id     = 4'($urandom_range(0, 7));
      issue_rd     = 5'($urandom_range(0, 7));
      issue_we     = ($urandom_range(0, 3) != 0);
      commit_valid = ($urandom_range(0, 5) == 0);
      commit_kill  = 1'($urandom_range(0, 1));
      commit_id    = 4'($urandom_range(0, 7));
      result_valid = ($urandom_range(0, 1) == 0);
      result_id    = 4'($urandom_range(0, 7));
      result_we    = ($urandom_range(0, 3) != 0);
      result_data  = $urandom();
      core_we      = 1'($urandom_range(0, 1));
      core_waddr   = 5'($urandom_range(0, 15));
      core_wdata   = $urandom();
      rs1          = 5'($urandom_range(0, 15));
      rs2          = 5'($urandom_range(0, 15));
      rd           = 5'($urandom_range(0, 15));
      step();
      if (n == 300) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
